// File: rtl/rx_frame_ctrl_pkg.sv
// Shared definitions for rx_frame_ctrl: command opcodes, FSM states and
// the register-file addresses that hold the two ALU operands.
package rx_frame_ctrl_pkg;

  localparam logic [7:0] CMD_WR     = 8'hAA;
  localparam logic [7:0] CMD_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU_NO = 8'hDD;

  localparam int ALU_A_ADDR = 0;
  localparam int ALU_B_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FUNC,
    ALU_WAIT,
    TX_LO,
    TX_HI
  } state_t;

endpackage

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: decodes command frames arriving byte-by-byte from a UART
// receiver, drives register-file and ALU strobes, and returns read data or
// ALU results through a valid/ready byte handshake.
// All outputs are registered; next values come from one combinational block.
// Optional: define RX_FRAME_CTRL_ERR_CNT_EN to add a saturating 8-bit
// ERR_CNT output counting FRAME_ERR pulses.
module rx_frame_ctrl
  import rx_frame_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_PAR_ERR,
  input  logic                  RX_STP_ERR,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_W-1:0]     RF_Address,
  output logic [DATA_W-1:0]     RF_WrData,
  input  logic [DATA_W-1:0]     RF_RdData,
  input  logic                  RF_RdData_VLD,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  input  logic [2*DATA_W-1:0]   ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic [DATA_W-1:0]     TX_P_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  FRAME_ERR
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
  ,
  output logic [7:0]            ERR_CNT
`endif
);

  state_t              state, nxt_state;
  logic [2*DATA_W-1:0] res_q, nxt_res;
  logic                nxt_wren, nxt_rden, nxt_alu_en, nxt_ferr, nxt_txv;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [DATA_W-1:0]   nxt_wdata, nxt_txd;
  logic [3:0]          nxt_fun;
  logic                consume, byte_ok, byte_bad;

  assign byte_ok  = RX_D_VLD & ~RX_PAR_ERR & ~RX_STP_ERR;
  assign byte_bad = RX_D_VLD & (RX_PAR_ERR | RX_STP_ERR);
  // Wait and transmit states ignore incoming bytes entirely, errors included.
  assign consume  = state inside {IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUNC};

  // Next-state and next-output decode; strobes default low, data holds.
  always_comb begin
    nxt_state  = state;
    nxt_wren   = 1'b0;
    nxt_rden   = 1'b0;
    nxt_alu_en = 1'b0;
    nxt_ferr   = 1'b0;
    nxt_addr   = RF_Address;
    nxt_wdata  = RF_WrData;
    nxt_fun    = ALU_FUN;
    nxt_res    = res_q;
    nxt_txd    = TX_P_DATA;
    nxt_txv    = TX_VALID;
    if (consume && byte_bad) begin
      nxt_ferr  = 1'b1;
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: if (byte_ok) begin
          case (RX_P_DATA)
            CMD_WR:     nxt_state = WR_ADDR;
            CMD_RD:     nxt_state = RD_ADDR;
            CMD_ALU_OP: nxt_state = OP_A;
            CMD_ALU_NO: nxt_state = ALU_FUNC;
            default:    nxt_ferr  = 1'b1;
          endcase
        end
        WR_ADDR: if (byte_ok) begin
          nxt_addr  = RX_P_DATA[ADDR_W-1:0];
          nxt_state = WR_DATA;
        end
        WR_DATA: if (byte_ok) begin
          nxt_wdata = RX_P_DATA;
          nxt_wren  = 1'b1;
          nxt_state = IDLE;
        end
        RD_ADDR: if (byte_ok) begin
          nxt_addr  = RX_P_DATA[ADDR_W-1:0];
          nxt_rden  = 1'b1;
          nxt_state = RD_WAIT;
        end
        RD_WAIT: if (RF_RdData_VLD) begin
          nxt_txd   = RF_RdData;
          nxt_txv   = 1'b1;
          nxt_state = TX_HI;
        end
        OP_A: if (byte_ok) begin
          nxt_addr  = ADDR_W'(ALU_A_ADDR);
          nxt_wdata = RX_P_DATA;
          nxt_wren  = 1'b1;
          nxt_state = OP_B;
        end
        OP_B: if (byte_ok) begin
          nxt_addr  = ADDR_W'(ALU_B_ADDR);
          nxt_wdata = RX_P_DATA;
          nxt_wren  = 1'b1;
          nxt_state = ALU_FUNC;
        end
        ALU_FUNC: if (byte_ok) begin
          nxt_fun    = RX_P_DATA[3:0];
          nxt_alu_en = 1'b1;
          nxt_state  = ALU_WAIT;
        end
        ALU_WAIT: if (ALU_OUT_VLD) begin
          nxt_res   = ALU_OUT;
          nxt_txd   = ALU_OUT[DATA_W-1:0];
          nxt_txv   = 1'b1;
          nxt_state = TX_LO;
        end
        // Low byte accepted: present high byte, keep TX_VALID asserted.
        TX_LO: if (TX_READY) begin
          nxt_txd   = res_q[2*DATA_W-1:DATA_W];
          nxt_state = TX_HI;
        end
        TX_HI: if (TX_READY) begin
          nxt_txv   = 1'b0;
          nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // State and output registers; reset wins over any frame in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      res_q      <= '0;
      TX_P_DATA  <= '0;
      TX_VALID   <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      state      <= nxt_state;
      RF_WrEn    <= nxt_wren;
      RF_RdEn    <= nxt_rden;
      RF_Address <= nxt_addr;
      RF_WrData  <= nxt_wdata;
      ALU_EN     <= nxt_alu_en;
      ALU_FUN    <= nxt_fun;
      res_q      <= nxt_res;
      TX_P_DATA  <= nxt_txd;
      TX_VALID   <= nxt_txv;
      FRAME_ERR  <= nxt_ferr;
    end
  end

`ifdef RX_FRAME_CTRL_ERR_CNT_EN
  // Saturating count of discarded frames, updated with each FRAME_ERR pulse.
  always_ff @(posedge CLK) begin
    if (RST)                            ERR_CNT <= '0;
    else if (nxt_ferr && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: write, read, ALU-with-operands frames,
// error discard, unknown opcode and reset during ALU wait.
module tb_rx_frame_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD, RX_PAR_ERR, RX_STP_ERR;
  logic        RF_WrEn, RF_RdEn;
  logic [3:0]  RF_Address;
  logic [7:0]  RF_WrData, RF_RdData;
  logic        RF_RdData_VLD;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  TX_P_DATA;
  logic        TX_VALID, TX_READY, FRAME_ERR;
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
  logic [7:0]  ERR_CNT;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rx_frame_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .FRAME_ERR(FRAME_ERR)
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns past the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one byte for one cycle; returns just after the edge that took it.
  task automatic send(input logic [7:0] b, input logic perr = 1'b0, input logic serr = 1'b0);
    RX_P_DATA  = b;
    RX_D_VLD   = 1'b1;
    RX_PAR_ERR = perr;
    RX_STP_ERR = serr;
    step();
    RX_D_VLD   = 1'b0;
    RX_PAR_ERR = 1'b0;
    RX_STP_ERR = 1'b0;
  endtask

  initial begin
    RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 0; RX_PAR_ERR = 0; RX_STP_ERR = 0;
    RF_RdData = '0; RF_RdData_VLD = 0; ALU_OUT = '0; ALU_OUT_VLD = 0; TX_READY = 0;
    step(); step();
    chk("rst_wren", RF_WrEn, 0);
    chk("rst_addr", RF_Address, 0);
    chk("rst_txv", TX_VALID, 0);
    chk("rst_ferr", FRAME_ERR, 0);
    chk("rst_fun", ALU_FUN, 0);
    RST = 1'b0;
    step();

    // Stray read-valid in IDLE must not start a transmit.
    RF_RdData = 8'h99; RF_RdData_VLD = 1;
    step();
    RF_RdData_VLD = 0;
    chk("idle_rdvld_ign", TX_VALID, 0);

    // Write frame.
    send(8'hAA); send(8'h05);
    chk("wr_no_early", RF_WrEn, 0);
    send(8'h3C);
    chk("wr_en", RF_WrEn, 1);
    chk("wr_addr", RF_Address, 5);
    chk("wr_data", RF_WrData, 8'h3C);
    step();
    chk("wr_one_cyc", RF_WrEn, 0);

    // Read frame with a stray byte during RD_WAIT.
    send(8'hBB); send(8'h02);
    chk("rd_en", RF_RdEn, 1);
    chk("rd_addr", RF_Address, 2);
    send(8'hAA);
    chk("rd_en_one_cyc", RF_RdEn, 0);
    chk("rdwait_byte_ign", FRAME_ERR, 0);
    RF_RdData = 8'h7E; RF_RdData_VLD = 1;
    step();
    RF_RdData_VLD = 0; RF_RdData = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk("rd_txv_hold", TX_VALID, 1);
      chk("rd_txd_hold", TX_P_DATA, 8'h7E);
      step();
    end
    TX_READY = 1;
    step();
    TX_READY = 0;
    chk("rd_txv_drop", TX_VALID, 0);

    // ALU frame with operands.
    send(8'hCC);
    send(8'h10);
    chk("opa_wren", RF_WrEn, 1);
    chk("opa_addr", RF_Address, 0);
    chk("opa_data", RF_WrData, 8'h10);
    send(8'h20);
    chk("opb_wren", RF_WrEn, 1);
    chk("opb_addr", RF_Address, 1);
    chk("opb_data", RF_WrData, 8'h20);
    send(8'h01);
    chk("alu_en", ALU_EN, 1);
    chk("alu_fun", ALU_FUN, 1);
    chk("alu_no_wren", RF_WrEn, 0);
    step();
    chk("alu_en_one_cyc", ALU_EN, 0);
    ALU_OUT = 16'h0030; ALU_OUT_VLD = 1;
    step();
    ALU_OUT_VLD = 0; ALU_OUT = 16'hFFFF;
    chk("tx_lo_v", TX_VALID, 1);
    chk("tx_lo_d", TX_P_DATA, 8'h30);
    TX_READY = 1;
    step();
    chk("tx_hi_v", TX_VALID, 1);
    chk("tx_hi_d", TX_P_DATA, 8'h00);
    step();
    TX_READY = 0;
    chk("tx_done", TX_VALID, 0);

    // Parity error on the address byte drops the frame.
    send(8'hAA);
    send(8'h05, 1'b1);
    chk("perr_ferr", FRAME_ERR, 1);
    chk("perr_no_wren", RF_WrEn, 0);
    step();
    chk("perr_ferr_pulse", FRAME_ERR, 0);
    chk("perr_no_wren2", RF_WrEn, 0);
    send(8'hDD); send(8'h03);
    chk("dd_alu_en", ALU_EN, 1);
    chk("dd_alu_fun", ALU_FUN, 3);

    // Reset while in ALU_WAIT, then a late result.
    RST = 1;
    step();
    RST = 0;
    chk("rst_mid_fun", ALU_FUN, 0);
    chk("rst_mid_en", ALU_EN, 0);
    chk("rst_mid_txv", TX_VALID, 0);
    chk("rst_mid_addr", RF_Address, 0);
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1;
    step();
    ALU_OUT_VLD = 0;
    chk("late_alu_ign", TX_VALID, 0);

    // Unknown opcode.
    send(8'h55);
    chk("unk_ferr", FRAME_ERR, 1);
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
    chk("errcnt_1", ERR_CNT, 1);
`endif
    step();
    chk("unk_ferr_pulse", FRAME_ERR, 0);
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
    for (int i = 0; i < 299; i++) send(8'h55);
    chk("errcnt_sat", ERR_CNT, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
